// File: rtl/c5_mult.sv
// ----------------------------------------------------------------------------
// c5_mult -- iterative multiply/divide unit with HI/LO result registers.
//
// Receives the delayed operands and multiply function from the three-stage
// pipeline controller. MULT/MULTU/DIV/DIVU take 32 iterations, one per clock.
// MFHI/MFLO reads are combinational. A read issued while an operation is
// still iterating raises a pause request so the controller stalls the core.
//
// Ports
//   I_clk        in   1      clock, rising edge
//   I_rst        in   1      synchronous reset, active-high
//   I_a          in   WIDTH  operand A / dividend / MTHI-MTLO data
//   I_b          in   WIDTH  operand B / divisor
//   I_mult_func  in   4      operation select
//   O_c_mult     out  WIDTH  read data (LO or HI, else zero)
//   O_pause_out  out  1      stall request while a read waits for a result
// ----------------------------------------------------------------------------
module c5_mult #(
  parameter int WIDTH = 32
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic [WIDTH-1:0] I_a,
  input  logic [WIDTH-1:0] I_b,
  input  logic [3:0]       I_mult_func,
  output logic [WIDTH-1:0] O_c_mult,
  output logic             O_pause_out
);

  localparam logic [3:0] FN_NOTHING       = 4'b0000;
  localparam logic [3:0] FN_READ_LO       = 4'b0001;
  localparam logic [3:0] FN_READ_HI       = 4'b0010;
  localparam logic [3:0] FN_WRITE_LO      = 4'b0011;
  localparam logic [3:0] FN_WRITE_HI      = 4'b0100;
  localparam logic [3:0] FN_MULT          = 4'b0101;
  localparam logic [3:0] FN_SIGNED_MULT   = 4'b0110;
  localparam logic [3:0] FN_DIVIDE        = 4'b0111;
  localparam logic [3:0] FN_SIGNED_DIVIDE = 4'b1000;

  localparam logic [5:0] ITERATIONS = 6'd32;

  // Two's-complement negate when en is set. Used for sign correction of the
  // 64-bit product; wraps naturally for the -2^63 corner.
  function automatic logic [2*WIDTH-1:0] cond_neg64(input logic [2*WIDTH-1:0] v,
                                                    input logic en);
    logic signed [2*WIDTH-1:0] sv;
    sv = $signed(v);
    return en ? $unsigned(-sv) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg32(input logic [WIDTH-1:0] v,
                                                  input logic en);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return en ? $unsigned(-sv) : v;
  endfunction

  // Magnitude of a signed value. -2^31 maps to 0x80000000, which is exactly
  // the right unsigned magnitude, so no special case is needed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return cond_neg32(v, is_signed & v[WIDTH-1]);
  endfunction

  // Architectural and working state
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [5:0]         count_r;
  logic               mode_div_r;
  logic               negate_q_r;
  logic               negate_r_r;
  // op_a: multiplicand shifting left (mult) or dividend shifting out its MSB
  // (div). op_b: multiplier shifting right (mult) or static divisor (div).
  logic [2*WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0]   op_b_r;

  // Operation decode
  logic is_start;
  logic is_div;
  logic is_signed_op;
  logic div_by_zero;

  always_comb begin
    is_start     = 1'b0;
    is_div       = 1'b0;
    is_signed_op = 1'b0;
    case (I_mult_func)
      FN_MULT:          is_start = 1'b1;
      FN_SIGNED_MULT: begin
        is_start     = 1'b1;
        is_signed_op = 1'b1;
      end
      FN_DIVIDE: begin
        is_start = 1'b1;
        is_div   = 1'b1;
      end
      FN_SIGNED_DIVIDE: begin
        is_start     = 1'b1;
        is_div       = 1'b1;
        is_signed_op = 1'b1;
      end
      default: ;
    endcase
  end

  assign div_by_zero = is_div & (I_b == '0);

  // Start-time operand conditioning. A zero divisor keeps the raw dividend
  // and suppresses sign correction so HI ends up holding I_a unchanged and
  // LO all ones (every trial subtraction of zero succeeds).
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             start_neg_q;
  logic             start_neg_r;

  always_comb begin
    a_mag       = magnitude(I_a, is_signed_op & ~div_by_zero);
    b_mag       = magnitude(I_b, is_signed_op);
    start_neg_q = is_signed_op & ~div_by_zero & (I_a[WIDTH-1] ^ I_b[WIDTH-1]);
    start_neg_r = is_signed_op & ~div_by_zero & is_div & I_a[WIDTH-1];
  end

  // One multiply step: accumulate the shifted multiplicand into HI:LO
  // when the current multiplier bit is set.
  logic [2*WIDTH-1:0] prod_next;

  always_comb begin
    prod_next = {hi_r, lo_r} + (op_b_r[0] ? op_a_r : '0);
  end

  // One restoring divide step. The partial remainder is widened by two bits
  // so that the divide-by-zero case (remainder grows past 32 bits) still
  // reads as a non-negative trial and sets the quotient bit.
  logic [WIDTH:0]          rem_shift;
  logic signed [WIDTH+1:0] div_diff;
  logic                    q_bit;
  logic [WIDTH-1:0]        rem_next;
  logic [WIDTH-1:0]        quo_next;

  always_comb begin
    rem_shift = {hi_r, op_a_r[WIDTH-1]};
    div_diff  = $signed({1'b0, rem_shift}) - $signed({2'b00, op_b_r});
    q_bit     = ~div_diff[WIDTH+1];
    rem_next  = q_bit ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {lo_r[WIDTH-2:0], q_bit};
  end

  logic last_step;
  assign last_step = (count_r == 6'd1);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      hi_r       <= '0;
      lo_r       <= '0;
      count_r    <= '0;
      mode_div_r <= 1'b0;
      negate_q_r <= 1'b0;
      negate_r_r <= 1'b0;
      op_a_r     <= '0;
      op_b_r     <= '0;
    end else if (is_start) begin
      // A start while busy simply restarts with the new operands.
      count_r    <= ITERATIONS;
      mode_div_r <= is_div;
      negate_q_r <= start_neg_q;
      negate_r_r <= start_neg_r;
      op_a_r     <= {{WIDTH{1'b0}}, a_mag};
      op_b_r     <= b_mag;
      hi_r       <= '0;
      lo_r       <= '0;
    end else if (I_mult_func == FN_WRITE_LO) begin
      lo_r    <= I_a;
      count_r <= '0;
    end else if (I_mult_func == FN_WRITE_HI) begin
      hi_r    <= I_a;
      count_r <= '0;
    end else if (count_r != '0) begin
      count_r <= count_r - 6'd1;
      op_a_r  <= op_a_r << 1;
      if (mode_div_r) begin
        // Sign correction is folded into the final step so the corrected
        // result is visible the cycle after the 32nd iteration.
        hi_r <= last_step ? cond_neg32(rem_next, negate_r_r) : rem_next;
        lo_r <= last_step ? cond_neg32(quo_next, negate_q_r) : quo_next;
      end else begin
        op_b_r       <= op_b_r >> 1;
        {hi_r, lo_r} <= last_step ? cond_neg64(prod_next, negate_q_r) : prod_next;
      end
    end
  end

  // Read path and stall request
  always_comb begin
    O_c_mult    = '0;
    O_pause_out = 1'b0;
    case (I_mult_func)
      FN_READ_LO: begin
        O_c_mult    = lo_r;
        O_pause_out = (count_r != '0);
      end
      FN_READ_HI: begin
        O_c_mult    = hi_r;
        O_pause_out = (count_r != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_c5_mult.sv
module tb_c5_mult;

  localparam logic [3:0] NOP  = 4'b0000;
  localparam logic [3:0] RLO  = 4'b0001;
  localparam logic [3:0] RHI  = 4'b0010;
  localparam logic [3:0] WLO  = 4'b0011;
  localparam logic [3:0] WHI  = 4'b0100;
  localparam logic [3:0] MUL  = 4'b0101;
  localparam logic [3:0] SMUL = 4'b0110;
  localparam logic [3:0] DIV  = 4'b0111;
  localparam logic [3:0] SDIV = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic [3:0]  func = NOP;
  logic [31:0] c_mult;
  logic        pause;

  c5_mult #(.WIDTH(32)) dut (
    .I_clk      (clk),
    .I_rst      (rst),
    .I_a        (a),
    .I_b        (b),
    .I_mult_func(func),
    .O_c_mult   (c_mult),
    .O_pause_out(pause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          stall;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   stall_cnt   = 0;

  // Monitor: a read with pause low is a presented result; pause-high read
  // cycles are counted and compared against the expected stall length.
  always @(negedge clk) begin
    if (func == RLO || func == RHI) begin
      if (pause) begin
        stall_cnt++;
      end else begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_read: got data=%h with no expectation queued", c_mult);
        end else begin
          mon_e = sb.pop_front();
          if (c_mult !== mon_e.data || stall_cnt != mon_e.stall) begin
            miscompares++;
            $display("FAIL %s: got data=%h stall=%0d, expected data=%h stall=%0d",
                     mon_e.name, c_mult, stall_cnt, mon_e.data, mon_e.stall);
          end
        end
        stall_cnt = 0;
      end
    end
  end

  // Hold one function for exactly one rising edge.
  task automatic apply(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv);
    func = f;
    a    = av;
    b    = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(NOP, '0, '0);
  endtask

  // Present a read until the unit stops pausing, bounded by a cycle budget.
  task automatic do_read(input logic [3:0] f, input logic [31:0] exp_data,
                         input int exp_stall, input string name);
    exp_t e;
    bit   done;
    e.data  = exp_data;
    e.stall = exp_stall;
    e.name  = name;
    sb.push_back(e);
    func = f;
    a    = '0;
    b    = '0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!pause) done = 1'b1;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL %s_timeout: pause still high after 100 cycles, expected release", name);
      void'(sb.pop_back());
      stall_cnt = 0;
    end
    @(posedge clk);
    #1;
    func = NOP;
  endtask

  initial begin
    #1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset state
    do_read(RLO, 32'h0000_0000, 0, "reset_lo");
    do_read(RHI, 32'h0000_0000, 0, "reset_hi");

    // Unsigned multiply, read immediately: full 32-cycle stall
    apply(MUL, 32'hFFFF_FFFF, 32'h0000_0002);
    do_read(RHI, 32'h0000_0001, 32, "mult_hi");
    do_read(RLO, 32'hFFFF_FFFE, 0, "mult_lo");

    // Signed multiply -3 * 5
    apply(SMUL, 32'hFFFF_FFFD, 32'h0000_0005);
    idle(32);
    do_read(RHI, 32'hFFFF_FFFF, 0, "smult_hi");
    do_read(RLO, 32'hFFFF_FFF1, 0, "smult_lo");

    // Signed divide -7 / 2: quotient -3, remainder -1
    apply(SDIV, 32'hFFFF_FFF9, 32'h0000_0002);
    idle(32);
    do_read(RLO, 32'hFFFF_FFFD, 0, "sdiv_lo");
    do_read(RHI, 32'hFFFF_FFFF, 0, "sdiv_hi");

    // Unsigned divide 100 / 7, read after 10 cycles: 22 remaining
    apply(DIV, 32'd100, 32'd7);
    idle(10);
    do_read(RLO, 32'd14, 22, "div_lo");
    do_read(RHI, 32'd2, 0, "div_hi");

    // Divide by zero
    apply(DIV, 32'h1234_5678, 32'h0000_0000);
    idle(32);
    do_read(RLO, 32'hFFFF_FFFF, 0, "dz_lo");
    do_read(RHI, 32'h1234_5678, 0, "dz_hi");

    // Signed divide -2^31 / -1 wraps to 0x80000000, remainder 0
    apply(SDIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(32);
    do_read(RLO, 32'h8000_0000, 0, "sdiv_min_lo");
    do_read(RHI, 32'h0000_0000, 0, "sdiv_min_hi");

    // Direct HI/LO writes
    apply(WHI, 32'hAAAA_5555, '0);
    apply(WLO, 32'h0000_1234, '0);
    do_read(RHI, 32'hAAAA_5555, 0, "write_hi");
    do_read(RLO, 32'h0000_1234, 0, "write_lo");

    // Reset mid-operation discards the multiply
    apply(MUL, 32'd3, 32'd4);
    idle(9);
    rst = 1'b1;
    apply(NOP, '0, '0);
    rst = 1'b0;
    do_read(RLO, 32'h0000_0000, 0, "midreset_lo");
    do_read(RHI, 32'h0000_0000, 0, "midreset_hi");

    // WRITE_LO during multiply aborts it
    apply(MUL, 32'd3, 32'd4);
    idle(4);
    apply(WLO, 32'h0000_0055, '0);
    do_read(RLO, 32'h0000_0055, 0, "abort_lo");

    // New start while busy restarts with new operands
    apply(DIV, 32'd100, 32'd7);
    idle(4);
    apply(MUL, 32'd6, 32'd7);
    do_read(RLO, 32'd42, 32, "restart_lo");
    do_read(RHI, 32'd0, 0, "restart_hi");

    idle(2);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations: got %0d unconsumed, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
